// File: rtl/spi_adc_reader_if.sv
// Sample-request and ADC SPI pins of the MCP3002-style reader.
// slave = reader side, master = host/ADC side.
interface spi_adc_reader_if;
    logic       start;
    logic       channel;
    logic       adc_cs;
    logic       adc_sck;
    logic       adc_sdi;
    logic       adc_sdo;
    logic [9:0] data_out;
    logic       data_valid;
    logic       busy;

    modport slave (
        input  start,
        input  channel,
        input  adc_sdo,
        output adc_cs,
        output adc_sck,
        output adc_sdi,
        output data_out,
        output data_valid,
        output busy
    );

    modport master (
        output start,
        output channel,
        output adc_sdo,
        input  adc_cs,
        input  adc_sck,
        input  adc_sdi,
        input  data_out,
        input  data_valid,
        input  busy
    );
endinterface

// File: rtl/spi_adc_reader.sv
// One 16-clock SPI conversion on a 10-bit MCP3002-style ADC per start,
// result presented with a one-cycle data_valid strobe (PWM load).
module spi_adc_reader #(
    parameter int unsigned CLK_DIV = 25
) (
    input logic              clk,
    input logic              reset,
    spi_adc_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    localparam logic [9:0] RELOAD = 10'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [9:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] sr_q, sr_d;
    logic        chan_q, chan_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [9:0]  data_q, data_d;
    logic        accept;
    logic        unused_sr_hi;

    // DONE also accepts, so a held start gives exactly one CS-high cycle
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign unused_sr_hi = ^sr_q[15:10];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        chan_d  = chan_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
            end
            SETUP: begin
                if (div_q == 10'd0) begin
                    sck_d   = 1'b1;
                    sr_d    = {sr_q[14:0], bus.adc_sdo};
                    bit_d   = 5'd1;
                    div_d   = RELOAD;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - 10'd1;
                end
            end
            SHIFT: begin
                if (div_q != 10'd0) begin
                    div_d = div_q - 10'd1;
                end else if (sck_q) begin
                    sck_d = 1'b0;
                    div_d = RELOAD;
                    unique case (bit_q)
                        5'd1:    sdi_d = 1'b1;
                        5'd2:    sdi_d = chan_q;
                        5'd3:    sdi_d = 1'b1;
                        default: sdi_d = 1'b0;
                    endcase
                end else if (bit_q == 5'd16) begin
                    state_d = DONE;
                    cs_d    = 1'b1;
                    data_d  = sr_q[9:0];
                    valid_d = 1'b1;
                    div_d   = 10'd0;
                    bit_d   = 5'd0;
                end else begin
                    sck_d = 1'b1;
                    sr_d  = {sr_q[14:0], bus.adc_sdo};
                    bit_d = bit_q + 5'd1;
                    div_d = RELOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = SETUP;
            chan_d  = bus.channel;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            sdi_d   = 1'b1;
            busy_d  = 1'b1;
            div_d   = RELOAD;
            bit_d   = 5'd0;
            sr_d    = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 10'd0;
            bit_q   <= 5'd0;
            sr_q    <= 16'd0;
            chan_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            chan_q  <= chan_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.adc_cs     = cs_q;
    assign bus.adc_sck    = sck_q;
    assign bus.adc_sdi    = sdi_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader at CLK_DIV=2 and CLK_DIV=1
// with a behavioural MCP3002 data model and a PWM load register.
module tb_spi_adc_reader;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_adc_reader_if if2();
    spi_adc_reader_if if1();

    spi_adc_reader #(.CLK_DIV(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    spi_adc_reader #(.CLK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC model: bit for rise k is presented before rise k, D9 at rise 7
    logic [9:0] smp2 = 10'd0;
    logic [9:0] smp1 = 10'd0;
    int rc2 = 0;
    int rc1 = 0;
    int rises2 = 0;
    logic [3:0] cmd2 = 4'd0;

    always @(posedge if2.adc_sck or posedge if2.adc_cs) begin
        if (if2.adc_cs) begin
            rc2 = 0;
        end else begin
            if (rc2 < 4) cmd2[3 - rc2] = if2.adc_sdi;
            rc2 = rc2 + 1;
            rises2 = rises2 + 1;
        end
    end

    always @(posedge if1.adc_sck or posedge if1.adc_cs) begin
        if (if1.adc_cs) rc1 = 0;
        else rc1 = rc1 + 1;
    end

    always @* begin
        if (rc2 >= 6 && rc2 <= 15) if2.adc_sdo = smp2[15 - rc2];
        else if2.adc_sdo = 1'b0;
    end

    always @* begin
        if (rc1 >= 6 && rc1 <= 15) if1.adc_sdo = smp1[15 - rc1];
        else if1.adc_sdo = 1'b0;
    end

    logic [9:0] pwm_reg = 10'd0;
    always @(posedge clk) begin
        if (if2.data_valid === 1'b1) pwm_reg <= if2.data_out;
    end

    int vtot2 = 0;
    always @(negedge clk) begin
        if (if2.data_valid === 1'b1) vtot2++;
    end

    int vfirst, vcnt, bfall, sck_first;
    logic [9:0] vdata;
    logic cs0, busy_end, cs_end;

    task automatic start_frame2();
        @(negedge clk);
        if2.start = 1'b1;
        @(posedge clk);
        #1 if2.start = 1'b0;
    endtask

    task automatic watch2(input int ncyc, input int p1, input int p2);
        vfirst = -1;
        vcnt = 0;
        bfall = -1;
        sck_first = -1;
        vdata = 10'h0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (n == 0) cs0 = if2.adc_cs;
            if (if2.data_valid === 1'b1) begin
                if (vfirst < 0) vfirst = n;
                vcnt++;
                vdata = if2.data_out;
            end
            if (if2.busy === 1'b0 && bfall < 0) bfall = n;
            if (if2.adc_sck === 1'b1 && sck_first < 0) sck_first = n;
            if (n == p1 - 1 || n == p2 - 1) if2.start = 1'b1;
            if (n == p1 || n == p2) if2.start = 1'b0;
            busy_end = if2.busy;
            cs_end = if2.adc_cs;
        end
    endtask

    int vpos[3];
    int vk, cs_hi;
    logic s1, s2, s3;
    logic [9:0] d1;
    int snap;

    initial begin
        reset = 1'b1;
        if2.start = 1'b0;
        if2.channel = 1'b0;
        if1.start = 1'b0;
        if1.channel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cs", if2.adc_cs, 1);
        check("rst_sck", if2.adc_sck, 0);
        check("rst_sdi", if2.adc_sdi, 0);
        check("rst_data", if2.data_out, 0);
        check("rst_valid", if2.data_valid, 0);
        check("rst_busy", if2.busy, 0);
        reset = 1'b0;

        smp2 = 10'h2A5;
        rises2 = 0;
        start_frame2();
        watch2(70, -1, -1);
        check("t1_cs_low", cs0, 0);
        check("t1_sck_first", sck_first, 2);
        check("t1_cmd", cmd2, 4'b1101);
        check("t1_rises", rises2, 16);
        check("t1_vpos", vfirst, 66);
        check("t1_vcnt", vcnt, 1);
        check("t1_data", vdata, 10'h2A5);
        check("t1_busy_fall", bfall, 67);

        smp2 = 10'h3FF;
        if2.channel = 1'b1;
        rises2 = 0;
        start_frame2();
        if2.channel = 1'b0;
        watch2(70, -1, -1);
        check("t2a_cmd", cmd2, 4'b1111);
        check("t2a_vcnt", vcnt, 1);
        check("t2a_data", vdata, 10'h3FF);

        smp2 = 10'h000;
        if2.channel = 1'b1;
        rises2 = 0;
        start_frame2();
        watch2(70, -1, -1);
        check("t2b_vcnt", vcnt, 1);
        check("t2b_data", vdata, 10'h000);
        check("t2b_rises", rises2, 16);
        if2.channel = 1'b0;

        smp2 = 10'h1C3;
        start_frame2();
        watch2(80, 10, 40);
        check("t3_vcnt", vcnt, 1);
        check("t3_vpos", vfirst, 66);
        check("t3_data", vdata, 10'h1C3);
        check("t3_busy_end", busy_end, 0);
        check("t3_cs_end", cs_end, 1);

        smp2 = 10'h3FF;
        start_frame2();
        repeat (30) @(negedge clk);
        check("t4_cs_mid", if2.adc_cs, 0);
        snap = vtot2;
        reset = 1'b1;
        #1;
        check("t4_cs", if2.adc_cs, 1);
        check("t4_sck", if2.adc_sck, 0);
        check("t4_busy", if2.busy, 0);
        check("t4_data", if2.data_out, 0);
        check("t4_valid", if2.data_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_valid", vtot2, snap);

        smp2 = 10'd256;
        rises2 = 0;
        start_frame2();
        watch2(70, -1, -1);
        check("t5_vpos", vfirst, 66);
        check("t5_data", vdata, 10'd256);
        check("t5_rises", rises2, 16);
        check("t5_pwm", pwm_reg, 10'd256);

        smp1 = 10'h155;
        vpos[0] = -1;
        vpos[1] = -1;
        vpos[2] = -1;
        vk = 0;
        cs_hi = 0;
        d1 = 10'h0;
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (n == 1) s1 = if1.adc_sck;
            if (n == 2) s2 = if1.adc_sck;
            if (n == 3) s3 = if1.adc_sck;
            if (if1.data_valid === 1'b1 && vk < 3) begin
                vpos[vk] = n;
                if (vk == 1) d1 = if1.data_out;
                vk++;
            end
            if (vk == 1 && if1.adc_cs === 1'b1) cs_hi++;
        end
        if1.start = 1'b0;
        check("t6_sck_n1", s1, 1);
        check("t6_sck_n2", s2, 0);
        check("t6_sck_n3", s3, 1);
        check("t6_v0", vpos[0], 33);
        check("t6_gap1", vpos[1] - vpos[0], 34);
        check("t6_gap2", vpos[2] - vpos[1], 34);
        check("t6_cs_gap", cs_hi, 1);
        check("t6_data", d1, 10'h155);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
